// File: rtl/ffq_pkg.sv
// rtl/ffq_pkg.sv - shared state encoding, 7-segment codes and winner-code check for the buzzer quiz
package ffq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ANSWER = 2'd2,
    ST_CLEAR  = 2'd3
  } ffq_state_e;

  localparam int NPLAYERS_DEF = 4;

  // Segment order is {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;

  // A winner code is a player number 1..nplayers; 0 means nobody buzzed.
  function automatic logic winner_valid(input logic [3:0] code, input int nplayers);
    return (code != 4'd0) && (int'(code) <= nplayers);
  endfunction

endpackage

// File: rtl/ffq_seg7_dec.sv
// rtl/ffq_seg7_dec.sv - combinational decimal digit to 7-segment decoder, blank outside 1..9
module ffq_seg7_dec
  import ffq_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Digits 1..9 light their glyph; 0 (no winner) and anything above 9 stay dark.
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ffq_host_ctrl.sv
// rtl/ffq_host_ctrl.sv - quiz round controller: arms buzzers, times answers, keeps scores (optional FFQ_PENALTY_EN)
module ffq_host_ctrl
  import ffq_pkg::*;
#(
  parameter int NPLAYERS   = NPLAYERS_DEF,
  parameter int ANS_CYCLES = 1000,
  parameter int SCORE_W    = 4,
  parameter int MAX_SCORE  = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        judge_ok,
  input  logic                        judge_bad,
  input  logic                        flag_in,
  input  logic [3:0]                  winner_in,
  output logic                        buzz_en,
  output logic                        buzz_clear,
  output logic [3:0]                  winner,
  output logic [6:0]                  seg,
  output logic                        timeout,
  output logic [1:0]                  state,
  output logic [NPLAYERS*SCORE_W-1:0] scores
);

  localparam int                 TW         = $clog2(ANS_CYCLES);
  localparam logic [TW-1:0]      TIMER_LOAD = TW'(ANS_CYCLES - 1);
  localparam logic [SCORE_W-1:0] MAX_S      = SCORE_W'(MAX_SCORE);

  ffq_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    winner_q, winner_d;
  logic [6:0]    seg_q, seg_d;
  logic          timeout_q, timeout_d;
  logic          buzz_en_q, buzz_clear_q;
  logic          score_inc, score_dec;
  logic [NPLAYERS-1:0][SCORE_W-1:0] score_q, score_d;

  // Decode the next winner so the digit changes on the same edge as the winner register.
  ffq_seg7_dec u_seg_dec (
    .digit_i (winner_d),
    .seg_o   (seg_d)
  );

  // Round sequencing: abort outranks everything, a clean judgement outranks the timer expiring.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    winner_d  = winner_q;
    timeout_d = 1'b0;
    score_inc = 1'b0;
    score_dec = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (abort) begin
          state_d = ST_CLEAR;
        end else if (flag_in && winner_valid(winner_in, NPLAYERS)) begin
          winner_d = winner_in;
          timer_d  = TIMER_LOAD;
          state_d  = ST_ANSWER;
        end
      end
      ST_ANSWER: begin
        if (timer_q != '0) timer_d = timer_q - TW'(1);
        if (abort) begin
          state_d = ST_CLEAR;
        end else if (judge_ok && !judge_bad) begin
          score_inc = 1'b1;
          state_d   = ST_CLEAR;
        end else if (judge_bad && !judge_ok) begin
`ifdef FFQ_PENALTY_EN
          score_dec = 1'b1;
`endif
          state_d   = ST_CLEAR;
        end else if (timer_q == '0) begin
          timeout_d = 1'b1;
`ifdef FFQ_PENALTY_EN
          score_dec = 1'b1;
`endif
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        winner_d = 4'd0;
        state_d  = ST_IDLE;
      end
      default: begin
        winner_d = 4'd0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Only the current winner's score moves, saturating at both ends.
  always_comb begin
    score_d = score_q;
    for (int p = 0; p < NPLAYERS; p++) begin
      if (winner_q == 4'(p + 1)) begin
        if (score_inc && (score_q[p] < MAX_S)) begin
          score_d[p] = score_q[p] + SCORE_W'(1);
        end else if (score_dec && (score_q[p] != '0)) begin
          score_d[p] = score_q[p] - SCORE_W'(1);
        end
      end
    end
  end

  // All outputs are registered; buzzer strobes follow the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      winner_q     <= 4'd0;
      seg_q        <= SEG_BLANK;
      timeout_q    <= 1'b0;
      buzz_en_q    <= 1'b0;
      buzz_clear_q <= 1'b0;
      score_q      <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      winner_q     <= winner_d;
      seg_q        <= seg_d;
      timeout_q    <= timeout_d;
      buzz_en_q    <= (state_d == ST_ARMED);
      buzz_clear_q <= (state_d == ST_CLEAR);
      score_q      <= score_d;
    end
  end

  assign state      = state_q;
  assign winner     = winner_q;
  assign seg        = seg_q;
  assign timeout    = timeout_q;
  assign buzz_en    = buzz_en_q;
  assign buzz_clear = buzz_clear_q;
  assign scores     = score_q;

endmodule
